ring_buf_reader: RTL

//  Read-side controller for a single-clock ring buffer whose write side is owned by a separate writer block.

---
 rtl/ring_buf_reader.sv | 114 +++++++++++
 1 files changed

// File: rtl/ring_buf_reader.sv
// Read-side controller for a single-clock ring buffer: fetches entries from a
// 1-cycle-latency RAM into a 2-entry FIFO and streams them out on valid/ready.
module ring_buf_reader #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW:0]   wr_ptr,
    output logic [AW:0]   rd_ptr,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow_err,
    output logic [1:0]    fsm_state
);

    // Stream handshake: a word transfers on a rising edge where out_valid && out_ready;
    // while out_valid && !out_ready, out_valid and out_data hold their values.

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } occ_e;

    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(2**AW);

    occ_e          state;
    occ_e          state_nxt;
    logic [AW:0]   iss_ptr;
    logic [AW:0]   rd_q;
    logic          in_flight;
    logic          ovf_q;
    logic [DW-1:0] buf0;
    logic [DW-1:0] buf1;
    logic          pop;
    logic          capture;
    logic          issue;
    logic [1:0]    pending;

    // Words already committed to the buffer after this edge; a fetch is
    // only started when it is guaranteed a free slot on return.
    always_comb begin
        pop     = (state != S_EMPTY) && out_ready;
        capture = in_flight;
        pending = 2'(state) + 2'(in_flight) - 2'(pop);
        issue   = !rst && (iss_ptr != wr_ptr) && (pending < 2'd2);
    end

    always_comb begin
        state_nxt = state;
        if (capture && !pop) begin
            case (state)
                S_EMPTY: state_nxt = S_ONE;
                S_ONE:   state_nxt = S_TWO;
                default: state_nxt = state;
            endcase
        end else if (pop && !capture) begin
            case (state)
                S_TWO:   state_nxt = S_ONE;
                S_ONE:   state_nxt = S_EMPTY;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_EMPTY;
            iss_ptr   <= '0;
            rd_q      <= '0;
            in_flight <= 1'b0;
            ovf_q     <= 1'b0;
            buf0      <= '0;
            buf1      <= '0;
        end else begin
            state     <= state_nxt;
            in_flight <= issue;
            if (issue) iss_ptr <= iss_ptr + PTR_ONE;
            if (pop) rd_q <= rd_q + PTR_ONE;
            if (count > DEPTH_LIM) ovf_q <= 1'b1;
            // buf0 is always the oldest word; buf1 only used when two are held.
            if (pop) begin
                if (state == S_TWO) begin
                    buf0 <= buf1;
                    if (capture) buf1 <= mem_rdata;
                end else if (capture) begin
                    buf0 <= mem_rdata;
                end
            end else if (capture) begin
                if (state == S_EMPTY) buf0 <= mem_rdata;
                else buf1 <= mem_rdata;
            end
        end
    end

    assign mem_en       = issue;
    assign mem_addr     = iss_ptr[AW-1:0];
    assign rd_ptr       = rd_q;
    assign out_valid    = (state != S_EMPTY);
    assign out_data     = buf0;
    assign count        = wr_ptr - rd_q;
    assign empty        = (rd_q == wr_ptr);
    assign overflow_err = ovf_q;
    assign fsm_state    = state;

endmodule
